// File: rtl/div_radix2_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the EX-stage divide handshake.
// Produces one quotient bit per clock; result_o = {remainder, quotient}.
module div_radix2_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_dvd;     // dividend shifts out as quotient shifts in
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_rem;
    logic               r_sign1, r_sign2, r_signed;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic               w_go, w_abort, w_last, w_ge, w_div_zero;
    logic [WIDTH-1:0]   w_abs1, w_abs2, w_rem_nx, w_quo_nx, w_q_fix, w_r_fix;
    logic [WIDTH:0]     w_rem_sh, w_diff;

    assign w_go       = start_i && !annul_i;
    assign w_abort    = annul_i || !start_i;
    assign w_div_zero = (opdata2_i == '0);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    assign w_abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? ('0 - opdata1_i) : opdata1_i;
    assign w_abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? ('0 - opdata2_i) : opdata2_i;

    // Bit WIDTH of the difference is the borrow: clear means rem_sh >= divisor.
    assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_ge     = ~w_diff[WIDTH];
    assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx = {r_dvd[WIDTH-2:0], w_ge};

    assign w_q_fix = (r_signed && (r_sign1 ^ r_sign2)) ? ('0 - w_quo_nx) : w_quo_nx;
    assign w_r_fix = (r_signed && r_sign1) ? ('0 - w_rem_nx) : w_rem_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_go) w_next = w_div_zero ? S_DONE : S_CALC;
            S_CALC: begin
                if (w_abort)     w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            S_DONE: if (w_abort) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_signed <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (w_go) begin
                        if (w_div_zero) begin
                            r_result <= '0;
                            r_ready  <= 1'b1;
                        end else begin
                            r_dvd    <= w_abs1;
                            r_dvs    <= w_abs2;
                            r_rem    <= '0;
                            r_cnt    <= '0;
                            r_sign1  <= opdata1_i[WIDTH-1];
                            r_sign2  <= opdata2_i[WIDTH-1];
                            r_signed <= signed_div_i;
                        end
                    end
                end
                S_CALC: begin
                    r_ready <= 1'b0;
                    if (!w_abort) begin
                        r_rem <= w_rem_nx;
                        r_dvd <= w_quo_nx;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_result <= {w_r_fix, w_q_fix};
                            r_ready  <= 1'b1;
                        end
                    end
                end
                S_DONE: if (w_abort) r_ready <= 1'b0;
                default: r_ready <= 1'b0;
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = (r_state == S_CALC);
endmodule

// File: tb/tb_div_radix2_unit.sv
// Directed bench for div_radix2_unit: latency, signed/unsigned results,
// divide-by-zero, annul, async reset mid-operation and back-to-back requests.
module tb_div_radix2_unit;
    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    div_radix2_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full request: start held until ready_o, one extra hold cycle in DONE, then release.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        int n;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        step();
        chk({tag, "_busy_e0"}, {63'd0, busy_o}, 64'd1);
        chk({tag, "_ready_e0"}, {63'd0, ready_o}, 64'd0);
        opdata1_i = 32'hDEAD_BEEF;
        opdata2_i = 32'h0;
        signed_div_i = ~sgn;
        n = 0;
        while (!ready_o && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd32);
        chk({tag, "_result"}, result_o, {er, eq});
        chk({tag, "_busy_done"}, {63'd0, busy_o}, 64'd0);
        step();
        chk({tag, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
        chk({tag, "_hold_result"}, result_o, {er, eq});
        start_i = 1'b0;
        step();
        chk({tag, "_drop_ready"}, {63'd0, ready_o}, 64'd0);
        chk({tag, "_retained"}, result_o, {er, eq});
    endtask

    initial begin
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        step();
        step();
        chk("reset_result", result_o, 64'd0);
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_busy", {63'd0, busy_o}, 64'd0);
        rst = 1'b0;
        step();
        chk("idle_ready", {63'd0, ready_o}, 64'd0);

        run_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run_div("u_5_max", 1'b0, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5);

        // Divide by zero: ready one edge after start sampled, result zero.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1234;
        opdata2_i    = 32'd0;
        start_i      = 1'b1;
        step();
        chk("dz_ready", {63'd0, ready_o}, 64'd1);
        chk("dz_result", result_o, 64'd0);
        chk("dz_busy", {63'd0, busy_o}, 64'd0);
        start_i = 1'b0;
        step();
        chk("dz_drop_ready", {63'd0, ready_o}, 64'd0);

        // Annul at CALC step 10.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        step();
        for (int i = 0; i < 10; i++) step();
        chk("annul_busy_before", {63'd0, busy_o}, 64'd1);
        annul_i = 1'b1;
        step();
        chk("annul_ready", {63'd0, ready_o}, 64'd0);
        chk("annul_busy", {63'd0, busy_o}, 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < 35; i++) begin
            step();
            chk("annul_no_ready", {63'd0, ready_o}, 64'd0);
        end
        run_div("u3_2", 1'b0, 32'd3, 32'd2, 32'd1, 32'd1);

        // start dropping mid-CALC behaves as annul.
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        step();
        step();
        step();
        start_i = 1'b0;
        step();
        chk("drop_busy", {63'd0, busy_o}, 64'd0);
        chk("drop_ready", {63'd0, ready_o}, 64'd0);

        // Async reset pulse between edges mid-CALC.
        start_i = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_result", result_o, 64'd0);
        chk("arst_ready", {63'd0, ready_o}, 64'd0);
        chk("arst_busy", {63'd0, busy_o}, 64'd0);
        #1;
        rst     = 1'b0;
        start_i = 1'b0;
        step();
        run_div("u100_7_post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

        // Back-to-back with a single start_i=0 cycle between.
        run_div("b2b_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
        run_div("b2b_10_4", 1'b0, 32'd10, 32'd4, 32'd2, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
